// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared LC-3b pipeline types for the hazard/stall controller.
// The FSM encoding is exported both as an enum and as plain 2-bit constants.
package hazard_stall_ctrl_pkg;

    typedef logic [2:0] lc3b_reg;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_BUBBLE   = 2'd1,
        HZ_FLUSH    = 2'd2,
        HZ_MEM_WAIT = 2'd3
    } lc3b_hazard_state;

    localparam logic [1:0] ST_RUN      = HZ_RUN;
    localparam logic [1:0] ST_BUBBLE   = HZ_BUBBLE;
    localparam logic [1:0] ST_FLUSH    = HZ_FLUSH;
    localparam logic [1:0] ST_MEM_WAIT = HZ_MEM_WAIT;

    // Wide enough for LOAD_USE_BUBBLES up to 3.
    localparam int BCNT_W = 2;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Stage-latch control interface: latch/cache side is master, controller is slave.
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    import hazard_stall_ctrl_pkg::*;

    lc3b_reg          id_sr1_reg;
    logic             id_sr1_used;
    lc3b_reg          id_sr2_reg;
    logic             id_sr2_used;
    logic             idex_valid;
    lc3b_reg          idex_dest;
    logic             idex_load;
    logic             idex_regfile_we;
    logic             exmem_branch_taken;
    logic             icache_req;
    logic             icache_resp;
    logic             dcache_req;
    logic             dcache_resp;

    logic             stall_pipeline;
    logic             stall_front;
    logic             idex_bubble;
    logic             flush;
    logic             load_pc;
    logic [1:0]       ctrl_state;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_sr1_reg, id_sr1_used, id_sr2_reg, id_sr2_used,
               idex_valid, idex_dest, idex_load, idex_regfile_we,
               exmem_branch_taken, icache_req, icache_resp, dcache_req, dcache_resp,
        input  stall_pipeline, stall_front, idex_bubble, flush, load_pc,
               ctrl_state, stall_cycles
    );

    modport slave (
        input  id_sr1_reg, id_sr1_used, id_sr2_reg, id_sr2_used,
               idex_valid, idex_dest, idex_load, idex_regfile_we,
               exmem_branch_taken, icache_req, icache_resp, dcache_req, dcache_resp,
        output stall_pipeline, stall_front, idex_bubble, flush, load_pc,
               ctrl_state, stall_cycles
    );

endinterface

// File: rtl/hazard_stall_ctrl_load_use_detect.sv
// Load-use dependency check between the decode sources and the ID/EX destination.
// R0 is treated as an ordinary register.
module load_use_detect
    import hazard_stall_ctrl_pkg::*;
(
    input  logic    idex_valid,
    input  logic    idex_load,
    input  logic    idex_regfile_we,
    input  lc3b_reg idex_dest,
    input  lc3b_reg id_sr1_reg,
    input  logic    id_sr1_used,
    input  lc3b_reg id_sr2_reg,
    input  logic    id_sr2_used,
    output logic    hazard
);

    lc3b_reg    src_reg [2];
    logic [1:0] src_used;
    logic [1:0] src_hit;

    assign src_reg[0]  = id_sr1_reg;
    assign src_reg[1]  = id_sr2_reg;
    assign src_used[0] = id_sr1_used;
    assign src_used[1] = id_sr2_used;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_used[gi] && (src_reg[gi] == idex_dest);
        end
    endgenerate

    assign hazard = idex_valid && idex_load && idex_regfile_we && (|src_hit);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central stall/flush controller for the 5-stage LC-3b pipeline: decides when
// the stage latches may capture, when to insert load-use bubbles and when to flush.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int CNT_W            = 16
) (
    input  logic              clk,
    input  logic              reset,
    hazard_stall_ctrl_if.slave bus
);

    localparam logic [BCNT_W-1:0] BUBBLE_RELOAD = BCNT_W'(LOAD_USE_BUBBLES - 1);
    localparam logic              MULTI_BUBBLE  = (LOAD_USE_BUBBLES > 1);

    logic [1:0]        state_reg, state_next;
    logic [BCNT_W-1:0] bcnt_reg, bcnt_next;
    logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;

    logic hazard;
    logic mem_wait;
    logic front_raw;
    logic flush_raw;

    load_use_detect u_load_use_detect (
        .idex_valid      (bus.idex_valid),
        .idex_load       (bus.idex_load),
        .idex_regfile_we (bus.idex_regfile_we),
        .idex_dest       (bus.idex_dest),
        .id_sr1_reg      (bus.id_sr1_reg),
        .id_sr1_used     (bus.id_sr1_used),
        .id_sr2_reg      (bus.id_sr2_reg),
        .id_sr2_used     (bus.id_sr2_used),
        .hazard          (hazard)
    );

    // A response in the same cycle as its request does not stall.
    assign mem_wait = (bus.icache_req & ~bus.icache_resp) |
                      (bus.dcache_req & ~bus.dcache_resp);

    always_comb begin
        state_next = state_reg;
        bcnt_next  = bcnt_reg;
        front_raw  = 1'b0;
        flush_raw  = 1'b0;
        if (mem_wait) begin
            // Latches are frozen, so whatever was pending re-evaluates on release.
            state_next = ST_MEM_WAIT;
        end else begin
            case (state_reg)
                ST_BUBBLE: begin
                    if (bus.exmem_branch_taken) begin
                        flush_raw  = 1'b1;
                        bcnt_next  = '0;
                        state_next = ST_FLUSH;
                    end else begin
                        front_raw  = 1'b1;
                        bcnt_next  = (bcnt_reg != '0) ? bcnt_reg - 1'b1 : '0;
                        state_next = (bcnt_next == '0) ? ST_RUN : ST_BUBBLE;
                    end
                end
                default: begin
                    // RUN, FLUSH and the MEM_WAIT exit cycle; in FLUSH EX/MEM is
                    // invalid so a taken branch there is spurious and ignored.
                    if (bus.exmem_branch_taken && (state_reg != ST_FLUSH)) begin
                        flush_raw  = 1'b1;
                        bcnt_next  = '0;
                        state_next = ST_FLUSH;
                    end else if (hazard) begin
                        front_raw  = 1'b1;
                        bcnt_next  = BUBBLE_RELOAD;
                        state_next = MULTI_BUBBLE ? ST_BUBBLE : ST_RUN;
                    end else if ((state_reg == ST_MEM_WAIT) && (bcnt_reg != '0)) begin
                        state_next = ST_BUBBLE;
                    end else begin
                        state_next = ST_RUN;
                    end
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if ((mem_wait || front_raw) && (stall_cnt_reg != '1)) begin
            stall_cnt_next = stall_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_RUN;
            bcnt_reg      <= '0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            bcnt_reg      <= bcnt_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign bus.stall_pipeline = mem_wait  & ~reset;
    assign bus.stall_front    = front_raw & ~reset;
    assign bus.idex_bubble    = front_raw & ~reset;
    assign bus.flush          = flush_raw & ~reset;
    assign bus.load_pc        = flush_raw & ~reset;
    assign bus.ctrl_state     = state_reg;
    assign bus.stall_cycles   = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: three instances (1 bubble, 3 bubbles,
// 4-bit counter) share one stimulus stream; expectations are queued per cycle.
module tb_hazard_stall_ctrl;
    import hazard_stall_ctrl_pkg::*;

    typedef struct packed {
        logic       rst;
        logic [2:0] sr1;
        logic       u1;
        logic [2:0] sr2;
        logic       u2;
        logic       iv;
        logic [2:0] dest;
        logic       ld;
        logic       we;
        logic       br;
        logic       ireq;
        logic       iresp;
        logic       dreq;
        logic       dresp;
    } stim_t;

    typedef struct packed {
        logic       sp;
        logic       sf;
        logic       bub;
        logic       fl;
        logic       lpc;
        logic [1:0] st;
    } exp_t;

    typedef struct packed {
        exp_t e1;
        exp_t e3;
    } sb_t;

    logic  clk;
    logic  rst;
    stim_t cur;
    sb_t   sb_q [$];
    int    tests  = 0;
    int    failed = 0;
    logic [15:0] e_cnt1, e_cnt3;
    logic [3:0]  e_cnt4;

    hazard_stall_ctrl_if #(.CNT_W(16)) if1 ();
    hazard_stall_ctrl_if #(.CNT_W(16)) if3 ();
    hazard_stall_ctrl_if #(.CNT_W(4))  if4 ();

    hazard_stall_ctrl #(.LOAD_USE_BUBBLES(1), .CNT_W(16)) u_d1 (.clk(clk), .reset(rst), .bus(if1.slave));
    hazard_stall_ctrl #(.LOAD_USE_BUBBLES(3), .CNT_W(16)) u_d3 (.clk(clk), .reset(rst), .bus(if3.slave));
    hazard_stall_ctrl #(.LOAD_USE_BUBBLES(1), .CNT_W(4))  u_d4 (.clk(clk), .reset(rst), .bus(if4.slave));

    assign rst = cur.rst;

    assign if1.id_sr1_reg = cur.sr1;  assign if1.id_sr1_used = cur.u1;
    assign if1.id_sr2_reg = cur.sr2;  assign if1.id_sr2_used = cur.u2;
    assign if1.idex_valid = cur.iv;   assign if1.idex_dest = cur.dest;
    assign if1.idex_load = cur.ld;    assign if1.idex_regfile_we = cur.we;
    assign if1.exmem_branch_taken = cur.br;
    assign if1.icache_req = cur.ireq; assign if1.icache_resp = cur.iresp;
    assign if1.dcache_req = cur.dreq; assign if1.dcache_resp = cur.dresp;

    assign if3.id_sr1_reg = cur.sr1;  assign if3.id_sr1_used = cur.u1;
    assign if3.id_sr2_reg = cur.sr2;  assign if3.id_sr2_used = cur.u2;
    assign if3.idex_valid = cur.iv;   assign if3.idex_dest = cur.dest;
    assign if3.idex_load = cur.ld;    assign if3.idex_regfile_we = cur.we;
    assign if3.exmem_branch_taken = cur.br;
    assign if3.icache_req = cur.ireq; assign if3.icache_resp = cur.iresp;
    assign if3.dcache_req = cur.dreq; assign if3.dcache_resp = cur.dresp;

    assign if4.id_sr1_reg = cur.sr1;  assign if4.id_sr1_used = cur.u1;
    assign if4.id_sr2_reg = cur.sr2;  assign if4.id_sr2_used = cur.u2;
    assign if4.idex_valid = cur.iv;   assign if4.idex_dest = cur.dest;
    assign if4.idex_load = cur.ld;    assign if4.idex_regfile_we = cur.we;
    assign if4.exmem_branch_taken = cur.br;
    assign if4.icache_req = cur.ireq; assign if4.icache_resp = cur.iresp;
    assign if4.dcache_req = cur.dreq; assign if4.dcache_resp = cur.dresp;

    exp_t o1, o3;
    logic [35:0] cnt_obs;
    assign o1 = {if1.stall_pipeline, if1.stall_front, if1.idex_bubble, if1.flush, if1.load_pc, if1.ctrl_state};
    assign o3 = {if3.stall_pipeline, if3.stall_front, if3.idex_bubble, if3.flush, if3.load_pc, if3.ctrl_state};
    assign cnt_obs = {if1.stall_cycles, if3.stall_cycles, if4.stall_cycles};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // Load into dest with decode reading it via SR2; SR1 reads an unrelated register.
    function automatic stim_t hz(input logic [2:0] dest);
        stim_t s;
        s = '0;
        s.iv = 1'b1; s.ld = 1'b1; s.we = 1'b1; s.dest = dest;
        s.sr2 = dest; s.u2 = 1'b1;
        s.sr1 = dest ^ 3'b100; s.u1 = 1'b1;
        return s;
    endfunction

    function automatic exp_t ex(input logic sp, input logic sf, input logic bub,
                                input logic fl, input logic lpc, input logic [1:0] st);
        exp_t e;
        e = {sp, sf, bub, fl, lpc, st};
        return e;
    endfunction

    function automatic logic [15:0] sat16(input logic [15:0] v, input logic inc);
        return (inc && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    function automatic logic [3:0] sat4(input logic [3:0] v, input logic inc);
        return (inc && v != 4'hF) ? v + 4'd1 : v;
    endfunction

    task automatic test_reset();
        stim_t s [6];
        exp_t  x1 [6];
        exp_t  x3 [6];
        for (int i = 0; i < 6; i++) begin
            s[i] = idle();
            s[i].ireq = 1'b1;
        end
        s[0].rst = 1'b1; s[1].rst = 1'b1; s[4].iresp = 1'b1; s[5].ireq = 1'b0;
        x1[0] = ex(0,0,0,0,0,0); x1[1] = ex(0,0,0,0,0,0);
        x1[2] = ex(1,0,0,0,0,0); x1[3] = ex(1,0,0,0,0,3);
        x1[4] = ex(0,0,0,0,0,3); x1[5] = ex(0,0,0,0,0,0);
        x3 = x1;
        for (int i = 0; i < 6; i++) begin
            sb_t e;
            @(posedge clk); #1;
            cur = s[i];
            sb_q.push_back({x1[i], x3[i]});
            @(negedge clk);
            e = sb_q.pop_front();
            tests++;
            if (o1 !== e.e1) begin failed++; $display("[TB] FAIL reset c%0d lub1: got %b want %b", i, o1, e.e1); end
            tests++;
            if (o3 !== e.e3) begin failed++; $display("[TB] FAIL reset c%0d lub3: got %b want %b", i, o3, e.e3); end
            tests++;
            if (cnt_obs !== {e_cnt1, e_cnt3, e_cnt4}) begin
                failed++; $display("[TB] FAIL reset c%0d stall_cycles: got %h want %h", i, cnt_obs, {e_cnt1, e_cnt3, e_cnt4});
            end
            e_cnt1 = s[i].rst ? '0 : sat16(e_cnt1, e.e1.sp | e.e1.sf);
            e_cnt3 = s[i].rst ? '0 : sat16(e_cnt3, e.e3.sp | e.e3.sf);
            e_cnt4 = s[i].rst ? '0 : sat4(e_cnt4, e.e1.sp | e.e1.sf);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_load_use();
        stim_t s [8];
        exp_t  x1 [8];
        exp_t  x3 [8];
        s[0] = hz(3'd2);
        s[1] = hz(3'd2); s[1].iv = 1'b0;
        s[2] = s[1];
        s[3] = idle();
        s[4] = idle(); s[4].iv = 1'b1; s[4].ld = 1'b1; s[4].we = 1'b1; s[4].dest = 3'd0;
        s[4].sr1 = 3'd0; s[4].u1 = 1'b1; s[4].sr2 = 3'd3; s[4].u2 = 1'b1;
        s[5] = s[4]; s[5].iv = 1'b0;
        s[6] = s[5];
        s[7] = idle();
        x1[0] = ex(0,1,1,0,0,0); x3[0] = ex(0,1,1,0,0,0);
        x1[1] = ex(0,0,0,0,0,0); x3[1] = ex(0,1,1,0,0,1);
        x1[2] = ex(0,0,0,0,0,0); x3[2] = ex(0,1,1,0,0,1);
        x1[3] = ex(0,0,0,0,0,0); x3[3] = ex(0,0,0,0,0,0);
        x1[4] = ex(0,1,1,0,0,0); x3[4] = ex(0,1,1,0,0,0);
        x1[5] = ex(0,0,0,0,0,0); x3[5] = ex(0,1,1,0,0,1);
        x1[6] = ex(0,0,0,0,0,0); x3[6] = ex(0,1,1,0,0,1);
        x1[7] = ex(0,0,0,0,0,0); x3[7] = ex(0,0,0,0,0,0);
        for (int i = 0; i < 8; i++) begin
            sb_t e;
            @(posedge clk); #1;
            cur = s[i];
            sb_q.push_back({x1[i], x3[i]});
            @(negedge clk);
            e = sb_q.pop_front();
            tests++;
            if (o1 !== e.e1) begin failed++; $display("[TB] FAIL load_use c%0d lub1: got %b want %b", i, o1, e.e1); end
            tests++;
            if (o3 !== e.e3) begin failed++; $display("[TB] FAIL load_use c%0d lub3: got %b want %b", i, o3, e.e3); end
            tests++;
            if (cnt_obs !== {e_cnt1, e_cnt3, e_cnt4}) begin
                failed++; $display("[TB] FAIL load_use c%0d stall_cycles: got %h want %h", i, cnt_obs, {e_cnt1, e_cnt3, e_cnt4});
            end
            e_cnt1 = sat16(e_cnt1, e.e1.sp | e.e1.sf);
            e_cnt3 = sat16(e_cnt3, e.e3.sp | e.e3.sf);
            e_cnt4 = sat4(e_cnt4, e.e1.sp | e.e1.sf);
        end
        $display("[TB] test_load_use done");
    endtask

    task automatic test_no_hazard();
        stim_t s [6];
        for (int i = 0; i < 6; i++) s[i] = hz(3'd2);
        s[0].u2 = 1'b0;
        s[1].iv = 1'b0;
        s[2].ld = 1'b0;
        s[3].we = 1'b0;
        s[4].dest = 3'd3;
        s[5].u2 = 1'b0; s[5].sr1 = 3'd2; s[5].u1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sb_t e;
            @(posedge clk); #1;
            cur = s[i];
            sb_q.push_back({ex(0,0,0,0,0,0), ex(0,0,0,0,0,0)});
            @(negedge clk);
            e = sb_q.pop_front();
            tests++;
            if (o1 !== e.e1) begin failed++; $display("[TB] FAIL no_hazard c%0d lub1: got %b want %b", i, o1, e.e1); end
            tests++;
            if (o3 !== e.e3) begin failed++; $display("[TB] FAIL no_hazard c%0d lub3: got %b want %b", i, o3, e.e3); end
            tests++;
            if (cnt_obs !== {e_cnt1, e_cnt3, e_cnt4}) begin
                failed++; $display("[TB] FAIL no_hazard c%0d stall_cycles: got %h want %h", i, cnt_obs, {e_cnt1, e_cnt3, e_cnt4});
            end
        end
        $display("[TB] test_no_hazard done");
    endtask

    task automatic test_branch_hazard();
        stim_t s [12];
        exp_t  x1 [12];
        exp_t  x3 [12];
        for (int i = 0; i < 12; i++) s[i] = idle();
        s[0] = hz(3'd2); s[0].br = 1'b1;
        s[3].br = 1'b1;
        s[4] = hz(3'd2); s[4].br = 1'b1;
        s[8] = hz(3'd2);
        s[9].br = 1'b1;
        x1[0]  = ex(0,0,0,1,1,0); x3[0]  = ex(0,0,0,1,1,0);
        x1[1]  = ex(0,0,0,0,0,2); x3[1]  = ex(0,0,0,0,0,2);
        x1[2]  = ex(0,0,0,0,0,0); x3[2]  = ex(0,0,0,0,0,0);
        x1[3]  = ex(0,0,0,1,1,0); x3[3]  = ex(0,0,0,1,1,0);
        x1[4]  = ex(0,1,1,0,0,2); x3[4]  = ex(0,1,1,0,0,2);
        x1[5]  = ex(0,0,0,0,0,0); x3[5]  = ex(0,1,1,0,0,1);
        x1[6]  = ex(0,0,0,0,0,0); x3[6]  = ex(0,1,1,0,0,1);
        x1[7]  = ex(0,0,0,0,0,0); x3[7]  = ex(0,0,0,0,0,0);
        x1[8]  = ex(0,1,1,0,0,0); x3[8]  = ex(0,1,1,0,0,0);
        x1[9]  = ex(0,0,0,1,1,0); x3[9]  = ex(0,0,0,1,1,1);
        x1[10] = ex(0,0,0,0,0,2); x3[10] = ex(0,0,0,0,0,2);
        x1[11] = ex(0,0,0,0,0,0); x3[11] = ex(0,0,0,0,0,0);
        for (int i = 0; i < 12; i++) begin
            sb_t e;
            @(posedge clk); #1;
            cur = s[i];
            sb_q.push_back({x1[i], x3[i]});
            @(negedge clk);
            e = sb_q.pop_front();
            tests++;
            if (o1 !== e.e1) begin failed++; $display("[TB] FAIL branch_hazard c%0d lub1: got %b want %b", i, o1, e.e1); end
            tests++;
            if (o3 !== e.e3) begin failed++; $display("[TB] FAIL branch_hazard c%0d lub3: got %b want %b", i, o3, e.e3); end
            tests++;
            if (cnt_obs !== {e_cnt1, e_cnt3, e_cnt4}) begin
                failed++; $display("[TB] FAIL branch_hazard c%0d stall_cycles: got %h want %h", i, cnt_obs, {e_cnt1, e_cnt3, e_cnt4});
            end
            e_cnt1 = sat16(e_cnt1, e.e1.sp | e.e1.sf);
            e_cnt3 = sat16(e_cnt3, e.e3.sp | e.e3.sf);
            e_cnt4 = sat4(e_cnt4, e.e1.sp | e.e1.sf);
        end
        $display("[TB] test_branch_hazard done");
    endtask

    task automatic test_mem_wait();
        stim_t s [12];
        exp_t  x1 [12];
        exp_t  x3 [12];
        for (int i = 0; i < 12; i++) s[i] = idle();
        for (int i = 0; i < 5; i++) begin s[i].br = 1'b1; s[i].dreq = 1'b1; end
        s[4].dresp = 1'b1;
        s[7] = hz(3'd5); s[7].ireq = 1'b1;
        s[8] = hz(3'd5); s[8].ireq = 1'b1; s[8].iresp = 1'b1;
        s[9] = hz(3'd5); s[9].iv = 1'b0;
        s[10] = s[9];
        x1[0] = ex(1,0,0,0,0,0);
        for (int i = 1; i < 4; i++) x1[i] = ex(1,0,0,0,0,3);
        x1[4]  = ex(0,0,0,1,1,3);
        x1[5]  = ex(0,0,0,0,0,2);
        x1[6]  = ex(0,0,0,0,0,0);
        x1[7]  = ex(1,0,0,0,0,0);
        x1[8]  = ex(0,1,1,0,0,3);
        x1[9]  = ex(0,0,0,0,0,0);
        x1[10] = ex(0,0,0,0,0,0);
        x1[11] = ex(0,0,0,0,0,0);
        x3 = x1;
        x3[9]  = ex(0,1,1,0,0,1);
        x3[10] = ex(0,1,1,0,0,1);
        for (int i = 0; i < 12; i++) begin
            sb_t e;
            @(posedge clk); #1;
            cur = s[i];
            sb_q.push_back({x1[i], x3[i]});
            @(negedge clk);
            e = sb_q.pop_front();
            tests++;
            if (o1 !== e.e1) begin failed++; $display("[TB] FAIL mem_wait c%0d lub1: got %b want %b", i, o1, e.e1); end
            tests++;
            if (o3 !== e.e3) begin failed++; $display("[TB] FAIL mem_wait c%0d lub3: got %b want %b", i, o3, e.e3); end
            tests++;
            if (cnt_obs !== {e_cnt1, e_cnt3, e_cnt4}) begin
                failed++; $display("[TB] FAIL mem_wait c%0d stall_cycles: got %h want %h", i, cnt_obs, {e_cnt1, e_cnt3, e_cnt4});
            end
            e_cnt1 = sat16(e_cnt1, e.e1.sp | e.e1.sf);
            e_cnt3 = sat16(e_cnt3, e.e3.sp | e.e3.sf);
            e_cnt4 = sat4(e_cnt4, e.e1.sp | e.e1.sf);
        end
        $display("[TB] test_mem_wait done");
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 22; i++) begin
            sb_t   e;
            stim_t s;
            exp_t  x;
            s = idle();
            s.ireq = (i < 20);
            x = ex(i < 20, 0, 0, 0, 0, (i == 0 || i == 21) ? 2'd0 : 2'd3);
            @(posedge clk); #1;
            cur = s;
            sb_q.push_back({x, x});
            @(negedge clk);
            e = sb_q.pop_front();
            tests++;
            if (o1 !== e.e1) begin failed++; $display("[TB] FAIL saturation c%0d lub1: got %b want %b", i, o1, e.e1); end
            tests++;
            if (o3 !== e.e3) begin failed++; $display("[TB] FAIL saturation c%0d lub3: got %b want %b", i, o3, e.e3); end
            tests++;
            if (cnt_obs !== {e_cnt1, e_cnt3, e_cnt4}) begin
                failed++; $display("[TB] FAIL saturation c%0d stall_cycles: got %h want %h", i, cnt_obs, {e_cnt1, e_cnt3, e_cnt4});
            end
            e_cnt1 = sat16(e_cnt1, e.e1.sp | e.e1.sf);
            e_cnt3 = sat16(e_cnt3, e.e3.sp | e.e3.sf);
            e_cnt4 = sat4(e_cnt4, e.e1.sp | e.e1.sf);
        end
        tests++;
        if (if4.stall_cycles !== 4'hF) begin
            failed++; $display("[TB] FAIL saturation hold: got %0d want 15", if4.stall_cycles);
        end
        tests++;
        if (sb_q.size() != 0) begin
            failed++; $display("[TB] FAIL scoreboard drain: got %0d entries want 0", sb_q.size());
        end
        $display("[TB] test_saturation done");
    endtask

    initial begin
        cur     = idle();
        cur.rst = 1'b1;
        e_cnt1  = '0;
        e_cnt3  = '0;
        e_cnt4  = '0;
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch_hazard();
        test_mem_wait();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central stall/flush controller for the 5-stage LC-3b pipeline.
- Consumes the decode-stage source registers plus the ID/EX and EX/MEM latch outputs (dest, load/regfile-write control, branch resolution) and cache handshakes.
- Drives the `stall_pipeline` input of every stage latch, plus front-end freeze, ID/EX bubble-insert and flush controls.
- It is the control end of the stage-latch interface: the latches capture, this block decides when they may.

Parameters:
- LOAD_USE_BUBBLES, 1: bubbles inserted per load-use hazard (1..3).
- CNT_W, 16: width of the stall-cycle performance counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- id_sr1_reg  in  3  SR1 index of the instruction in decode
- id_sr1_used  in  1  decode instruction reads SR1
- id_sr2_reg  in  3  SR2 index of the instruction in decode
- id_sr2_used  in  1  decode instruction reads SR2
- idex_valid  in  1  ID/EX holds a real (non-bubble) instruction
- idex_dest  in  3  destination register in ID/EX
- idex_load  in  1  ID/EX instruction reads data memory (LDR/LDB/LDI)
- idex_regfile_we  in  1  ID/EX instruction writes the register file
- exmem_branch_taken  in  1  control transfer resolved taken in MEM
- icache_req  in  1  fetch request outstanding
- icache_resp  in  1  fetch complete
- dcache_req  in  1  data request outstanding
- dcache_resp  in  1  data complete
- stall_pipeline  out  1  freeze all stage latches and PC
- stall_front  out  1  freeze PC and IF/ID only
- idex_bubble  out  1  load NOP control word, valid=0 into ID/EX
- flush  out  1  squash IF/ID, ID/EX, EX/MEM (valid=0)
- load_pc  out  1  PC takes branch target this cycle
- ctrl_state  out  2  0=RUN, 1=BUBBLE, 2=FLUSH, 3=MEM_WAIT
- stall_cycles  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (`reset`=1 at `posedge clk`): state RUN, bubble counter 0, `stall_cycles` 0.
  - While `reset` is high, every combinational output is forced to 0.
- `mem_wait` = (`icache_req` & ~`icache_resp`) | (`dcache_req` & ~`dcache_resp`), computed combinationally.
  - `stall_pipeline` = `mem_wait`, with zero latency. A response in the same cycle as its request means no stall.
- `hazard` = `idex_valid` & `idex_load` & `idex_regfile_we` & ((`id_sr1_used` & `id_sr1_reg`==`idex_dest`) | (`id_sr2_used` & `id_sr2_reg`==`idex_dest`)).
- Priority, highest first: `mem_wait` > `exmem_branch_taken` > `hazard` / BUBBLE.
- While `stall_pipeline`=1:
  - `flush`, `load_pc`, `stall_front` and `idex_bubble` are 0.
  - State goes to MEM_WAIT, and the bubble counter holds.
  - Latched inputs are stable because the latches are frozen, so the deferred event re-evaluates on release.
- RUN:
  - `exmem_branch_taken` → `flush`=1 and `load_pc`=1 this cycle; next state FLUSH.
  - else `hazard` → `stall_front`=1 and `idex_bubble`=1 this cycle; counter loads LOAD_USE_BUBBLES-1; next state BUBBLE if LOAD_USE_BUBBLES>1, else RUN.
- BUBBLE:
  - `stall_front`=1 and `idex_bubble`=1.
  - Counter decrements; at 0 return to RUN.
  - `exmem_branch_taken` overrides: flush as in RUN, counter cleared, next state FLUSH.
- FLUSH:
  - One recovery cycle with no flush output; the squashed latches are already invalid.
  - A new `exmem_branch_taken` is impossible (EX/MEM invalid). If it is asserted anyway, ignore it.
  - Next state RUN; a `hazard` in this cycle is handled as in RUN.
- MEM_WAIT: exit on the first cycle `mem_wait`=0.
  - Return to BUBBLE if the counter is nonzero, else to RUN.
  - The exit cycle evaluates branch and hazard as in RUN.
- `stall_cycles` increments when `stall_pipeline` | `stall_front`, saturating at all-ones with no wrap.
- Register R0 as a destination is a genuine dependency: no special case.

Decomposition:
- lc3b_types gains `lc3b_hazard_state` (enum RUN/BUBBLE/FLUSH/MEM_WAIT) and `lc3b_reg`, reused from existing types.
- The hazard compare is kept as one sub-module, `load_use_detect` (pure combinational, outputs `hazard`).
- The FSM, counters and output logic live in `hazard_stall_ctrl`.

Test Plan:
1. Reset held 2 cycles with `icache_req`=1, `icache_resp`=0 → all outputs 0; after release, `stall_pipeline`=1 immediately and `ctrl_state`=3 next cycle.
2. LDR R2 in ID/EX (`idex_dest`=2, `idex_load`=1), decode ADD using `id_sr2_reg`=2 → one cycle of `stall_front`=1 and `idex_bubble`=1, then RUN; `stall_cycles`=1. With LOAD_USE_BUBBLES=3 → exactly 3 cycles.
3. Same hazard with `id_sr2_used`=0, or `idex_valid`=0 → no stall.
4. `exmem_branch_taken`=1 together with `hazard`=1 → `flush`=1, `load_pc`=1, `idex_bubble`=0; FLUSH state, then RUN.
5. `exmem_branch_taken`=1 while `dcache_req`=1, `dcache_resp` low for 4 cycles → `stall_pipeline`=1 for 4 cycles with `flush`=0; `flush` and `load_pc` pulse on cycle 5.
6. `stall_cycles` preset near saturation (CNT_W=4, 20 stalled cycles) → holds at 15.
